ahb_lite_txn_monitor: RTL and testbench

// Passive AHB-Lite transfer collector sitting directly downstream of the bench-side
// AHB-Lite signal bundle. Pairs each accepted address phase with its data phase.

---
 rtl/ahb_lite_txn_monitor.sv | 201 ++++++++++++++++++++
 tb/tb_ahb_lite_txn_monitor.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_txn_monitor.sv
// Passive AHB-Lite observer: pairs each accepted address phase with its data phase,
// queues one record per completed transfer and raises sticky protocol-violation flags.
module ahb_lite_txn_monitor #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic [1:0]       HSEL,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    input  logic             HWRITE,
    input  logic [2:0]       HSIZE,
    input  logic [2:0]       HBURST,
    input  logic [3:0]       HPROT,
    input  logic [31:0]      HWDATA,
    input  logic [31:0]      HRDATA,
    input  logic             HREADY,
    input  logic             HRESP,
    input  logic             clr_flags,
    input  logic             txn_ready,
    output logic             txn_valid,
    output logic [31:0]      txn_addr,
    output logic             txn_write,
    output logic [2:0]       txn_size,
    output logic [2:0]       txn_burst,
    output logic [3:0]       txn_prot,
    output logic [31:0]      txn_data,
    output logic             txn_resp,
    output logic [CNT_W-1:0] txn_count,
    output logic             err_ovf,
    output logic             err_resp,
    output logic             err_seq,
    output logic             err_size
);
    // state    | meaning
    // S_CLOSED | no burst in progress; any SEQ beat is a violation
    // S_OPEN   | NONSEQ accepted; SEQ beats checked against the previous beat

    localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_V = (PTR_W+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
        logic [31:0] data;
        logic        resp;
    } rec_t;

    typedef enum logic {S_CLOSED = 1'b0, S_OPEN = 1'b1} burst_state_t;

    burst_state_t     state, state_nxt;
    logic             burst_open, seq_bad;
    logic             accept, complete, is_nonseq, is_seq, idle_close, is_wrap;
    logic [31:0]      next_addr;

    logic             pend_valid;
    logic [31:0]      pend_addr;
    logic             pend_write;
    logic [2:0]       pend_size;
    logic [2:0]       pend_burst;
    logic [3:0]       pend_prot;
    logic [31:0]      last_addr;
    logic [2:0]       last_size;
    logic             err_wait_q;

    rec_t             mem [FIFO_DEPTH];
    rec_t             rec_in, head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   used;
    logic             full, pop, push_ok, drop;

    assign accept     = HREADY & (HSEL != 2'b00) & HTRANS[1];
    assign complete   = HREADY & pend_valid;
    assign is_nonseq  = accept & ~HTRANS[0];
    assign is_seq     = accept & HTRANS[0];
    assign idle_close = HREADY & (HTRANS == 2'b00);
    assign is_wrap    = (HBURST == 3'd2) | (HBURST == 3'd4) | (HBURST == 3'd6);
    assign next_addr  = last_addr + (32'd1 << last_size);

    always_ff @(posedge HCLK) begin
        if (HRESET) state <= S_CLOSED;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_CLOSED: if (is_nonseq)  state_nxt = S_OPEN;
            S_OPEN:   if (idle_close) state_nxt = S_CLOSED;
            default:                  state_nxt = S_CLOSED;
        endcase
    end

    // WRAP bursts wrap at a boundary, so only incrementing bursts get the address check
    always_comb begin
        burst_open = (state == S_OPEN);
        seq_bad    = is_seq & (~burst_open | (~is_wrap & (HADDR != next_addr)));
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_write <= 1'b0;
            pend_size  <= '0;
            pend_burst <= '0;
            pend_prot  <= '0;
            last_addr  <= '0;
            last_size  <= '0;
            err_wait_q <= 1'b0;
        end else begin
            err_wait_q <= HRESP & ~HREADY;
            if (accept) begin
                pend_valid <= 1'b1;
                pend_addr  <= HADDR;
                pend_write <= HWRITE;
                pend_size  <= HSIZE;
                pend_burst <= HBURST;
                pend_prot  <= HPROT;
                last_addr  <= HADDR;
                last_size  <= HSIZE;
            end else if (complete) begin
                pend_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        rec_in       = '0;
        rec_in.addr  = pend_addr;
        rec_in.write = pend_write;
        rec_in.size  = pend_size;
        rec_in.burst = pend_burst;
        rec_in.prot  = pend_prot;
        rec_in.data  = pend_write ? HWDATA : HRDATA;
        rec_in.resp  = HRESP;
    end

    assign full    = (used == DEPTH_V);
    assign pop     = txn_valid & txn_ready;
    assign push_ok = complete & (~full | pop);
    assign drop    = complete & full & ~pop;

    always_ff @(posedge HCLK) begin
        if (push_ok) mem[wr_ptr] <= rec_in;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            used      <= '0;
            txn_count <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr    <= wr_ptr + PTR_W'(1);
                txn_count <= txn_count + CNT_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   used <= used + (PTR_W+1)'(1);
                2'b01:   used <= used - (PTR_W+1)'(1);
                default: used <= used;
            endcase
        end
    end

    // A new violation in the same cycle as clr_flags wins over the clear
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            err_ovf  <= 1'b0;
            err_resp <= 1'b0;
            err_seq  <= 1'b0;
            err_size <= 1'b0;
        end else begin
            if (drop)                                err_ovf  <= 1'b1;
            else if (clr_flags)                      err_ovf  <= 1'b0;
            if (complete & HRESP & ~err_wait_q)      err_resp <= 1'b1;
            else if (clr_flags)                      err_resp <= 1'b0;
            if (seq_bad)                             err_seq  <= 1'b1;
            else if (clr_flags)                      err_seq  <= 1'b0;
            if (accept & (HSIZE > 3'd2))             err_size <= 1'b1;
            else if (clr_flags)                      err_size <= 1'b0;
        end
    end

    assign head      = mem[rd_ptr];
    assign txn_valid = (used != '0);
    assign txn_addr  = txn_valid ? head.addr  : 32'd0;
    assign txn_write = txn_valid ? head.write : 1'b0;
    assign txn_size  = txn_valid ? head.size  : 3'd0;
    assign txn_burst = txn_valid ? head.burst : 3'd0;
    assign txn_prot  = txn_valid ? head.prot  : 4'd0;
    assign txn_data  = txn_valid ? head.data  : 32'd0;
    assign txn_resp  = txn_valid ? head.resp  : 1'b0;

endmodule

// File: tb/tb_ahb_lite_txn_monitor.sv
// Randomised and directed bench for ahb_lite_txn_monitor: a transfer-level reference
// model queues expected records; a negedge monitor pops and compares delivered records.
`timescale 1ns/1ps
module tb_ahb_lite_txn_monitor;
    localparam int DEPTH = 4;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [1:0]  HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    logic        clr_flags;
    logic        txn_ready;
    logic        txn_valid;
    logic [31:0] txn_addr;
    logic        txn_write;
    logic [2:0]  txn_size;
    logic [2:0]  txn_burst;
    logic [3:0]  txn_prot;
    logic [31:0] txn_data;
    logic        txn_resp;
    logic [15:0] txn_count;
    logic        err_ovf, err_resp, err_seq, err_size;

    ahb_lite_txn_monitor #(.FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
        .clr_flags(clr_flags), .txn_ready(txn_ready), .txn_valid(txn_valid),
        .txn_addr(txn_addr), .txn_write(txn_write), .txn_size(txn_size),
        .txn_burst(txn_burst), .txn_prot(txn_prot), .txn_data(txn_data),
        .txn_resp(txn_resp), .txn_count(txn_count), .err_ovf(err_ovf),
        .err_resp(err_resp), .err_seq(err_seq), .err_size(err_size)
    );

    always #5 HCLK = ~HCLK;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
        logic [31:0] data;
        logic        resp;
    } rec_t;

    // resp_mode: 0 OKAY, 1 two-cycle ERROR, 2 single-cycle ERROR
    typedef struct packed {
        logic [1:0]  sel;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  waits;
        logic [1:0]  resp_mode;
    } xfer_t;

    localparam logic [1:0] NONSEQ = 2'd2;
    localparam logic [1:0] SEQ    = 2'd3;

    int          checks = 0;
    int          failures = 0;
    rec_t        exp_q[$];
    xfer_t       seqq[$];
    rec_t        mon_a, mon_e;
    bit          rand_ready = 0;
    bit          m_open, m_seq, m_size, m_resp, m_ovf;
    logic [31:0] m_last_addr;
    logic [2:0]  m_last_size;
    logic [15:0] m_count;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge HCLK) begin
        if (!HRESET && txn_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_record: got addr=%h data=%h, expected none at %0t",
                         txn_addr, txn_data, $time);
            end else if (txn_ready) begin
                mon_e = exp_q.pop_front();
                mon_a = '{addr: txn_addr, write: txn_write, size: txn_size, burst: txn_burst,
                          prot: txn_prot, data: txn_data, resp: txn_resp};
                checks++;
                if (mon_a !== mon_e) begin
                    failures++;
                    $display("FAIL record: got a=%h w=%0d s=%0d b=%0d p=%0h d=%h r=%0d expected a=%h w=%0d s=%0d b=%0d p=%0h d=%h r=%0d",
                             mon_a.addr, mon_a.write, mon_a.size, mon_a.burst, mon_a.prot, mon_a.data, mon_a.resp,
                             mon_e.addr, mon_e.write, mon_e.size, mon_e.burst, mon_e.prot, mon_e.data, mon_e.resp);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge HCLK);
        #1;
        if (rand_ready) txn_ready = ($urandom_range(0, 3) != 0);
    endtask

    function automatic xfer_t mk(input logic [1:0] trans, input logic [31:0] addr,
                                 input logic write, input logic [2:0] size,
                                 input logic [2:0] burst, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input logic [1:0] waits,
                                 input logic [1:0] resp_mode);
        xfer_t x;
        x.sel = 2'($urandom_range(1, 3));
        x.trans = trans;
        x.addr = addr;
        x.write = write;
        x.size = size;
        x.burst = burst;
        x.prot = 4'($urandom_range(0, 15));
        x.wdata = wdata;
        x.rdata = rdata;
        x.waits = waits;
        x.resp_mode = resp_mode;
        return x;
    endfunction

    task automatic put_addr(input xfer_t x);
        HSEL = x.sel; HTRANS = x.trans; HADDR = x.addr; HWRITE = x.write;
        HSIZE = x.size; HBURST = x.burst; HPROT = x.prot;
    endtask

    task automatic put_idle();
        HSEL = 2'd0; HTRANS = 2'd0; HADDR = 32'd0; HWRITE = 1'b0;
        HSIZE = 3'd0; HBURST = 3'd0; HPROT = 4'd0;
    endtask

    task automatic model_reset();
        m_open = 0; m_seq = 0; m_size = 0; m_resp = 0; m_ovf = 0;
        m_last_addr = 32'd0; m_last_size = 3'd0; m_count = 16'd0;
        exp_q.delete();
    endtask

    // Burst rules at transfer level: NONSEQ opens, SEQ must follow an open burst and,
    // unless wrapping, land exactly one beat after the previous accepted address.
    task automatic model_accept(input xfer_t x);
        if (x.size > 3'd2) m_size = 1;
        if (x.trans == NONSEQ) begin
            m_open = 1;
        end else if (x.trans == SEQ) begin
            if (!m_open) m_seq = 1;
            else if (!(x.burst inside {3'd2, 3'd4, 3'd6}) &&
                     x.addr != m_last_addr + (32'd1 << m_last_size)) m_seq = 1;
        end
        m_last_addr = x.addr;
        m_last_size = x.size;
    endtask

    task automatic check_flags(input string tag);
        check({tag, ".err_seq"},   64'(err_seq),   64'(m_seq));
        check({tag, ".err_size"},  64'(err_size),  64'(m_size));
        check({tag, ".err_resp"},  64'(err_resp),  64'(m_resp));
        check({tag, ".err_ovf"},   64'(err_ovf),   64'(m_ovf));
        check({tag, ".txn_count"}, 64'(txn_count), 64'(m_count));
    endtask

    // Drives a pipelined sequence: address of beat i+1 overlaps data phase of beat i.
    // With guard set, completion is stalled while the model says the FIFO is full.
    task automatic run_seq(input string tag, input bit guard);
        int   w;
        int   g;
        rec_t r;
        m_open = 0;
        foreach (seqq[i]) model_accept(seqq[i]);
        put_addr(seqq[0]);
        HREADY = 1; HRESP = 0;
        cyc();
        for (int i = 0; i < seqq.size(); i++) begin
            if (i + 1 < seqq.size()) put_addr(seqq[i+1]);
            else put_idle();
            HWDATA = seqq[i].write ? seqq[i].wdata : $urandom;
            HRDATA = $urandom;
            if (guard) begin
                g = 0;
                while (exp_q.size() >= DEPTH && g < 60) begin
                    HREADY = 0; HRESP = 0;
                    cyc();
                    g++;
                end
                if (g >= 60) check({tag, ".drain_timeout"}, 64'(exp_q.size()), 64'(DEPTH - 1));
            end
            w = int'(seqq[i].waits);
            if (seqq[i].resp_mode == 2'd1 && w == 0) w = 1;
            for (int k = 0; k < w; k++) begin
                HREADY = 0;
                HRESP = (seqq[i].resp_mode == 2'd1 && k == w - 1);
                cyc();
            end
            HREADY = 1;
            HRESP = (seqq[i].resp_mode != 2'd0);
            HRDATA = seqq[i].rdata;
            if (seqq[i].resp_mode == 2'd2) m_resp = 1;
            r = '{addr: seqq[i].addr, write: seqq[i].write, size: seqq[i].size,
                  burst: seqq[i].burst, prot: seqq[i].prot,
                  data: seqq[i].write ? seqq[i].wdata : seqq[i].rdata,
                  resp: (seqq[i].resp_mode != 2'd0)};
            if (exp_q.size() >= DEPTH && !txn_ready) m_ovf = 1;
            else begin
                exp_q.push_back(r);
                m_count++;
            end
            cyc();
        end
        put_idle();
        HREADY = 1; HRESP = 0; HWDATA = 32'd0;
        check_flags(tag);
    endtask

    task automatic do_reset();
        HRESET = 1; put_idle(); HREADY = 1; HRESP = 0; clr_flags = 0;
        HWDATA = 32'd0; HRDATA = 32'd0;
        cyc(); cyc();
        HRESET = 0;
        model_reset();
    endtask

    task automatic clear_flags();
        clr_flags = 1;
        cyc();
        clr_flags = 0;
        m_seq = 0; m_size = 0; m_resp = 0; m_ovf = 0;
    endtask

    task automatic drain(input string tag);
        int n;
        rand_ready = 0;
        txn_ready = 1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            cyc();
            n++;
        end
        cyc();
        check({tag, ".drained_left"}, 64'(exp_q.size()), 64'd0);
        check({tag, ".txn_valid"}, 64'(txn_valid), 64'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  sz;
        logic [2:0]  bt;
        logic [1:0]  rm;
        int          len, rr;

        txn_ready = 1;
        do_reset();
        check("reset.txn_valid", 64'(txn_valid), 64'd0);
        check("reset.txn_addr",  64'(txn_addr),  64'd0);
        check_flags("reset");

        seqq.delete();
        seqq.push_back(mk(NONSEQ, 32'h100, 1, 3'd2, 3'd0, 32'hDEADBEEF, 32'h0, 2'd0, 2'd0));
        run_seq("single_write", 1);
        check("single_write.count_is_1", 64'(txn_count), 64'd1);

        seqq.delete();
        seqq.push_back(mk(NONSEQ, 32'h200, 0, 3'd2, 3'd0, 32'h0, 32'h12345678, 2'd2, 2'd0));
        run_seq("read_waits", 1);
        drain("read_waits");

        seqq.delete();
        for (int i = 0; i < 4; i++)
            seqq.push_back(mk(i == 0 ? NONSEQ : SEQ, 32'h40 + 32'(4 * i), 1, 3'd2, 3'd3,
                              $urandom, 32'h0, 2'd0, 2'd0));
        run_seq("incr4_ok", 1);
        check("incr4_ok.no_err_seq", 64'(err_seq), 64'd0);
        seqq[2].addr = 32'h50;
        seqq[3].addr = 32'h54;
        run_seq("incr4_bad", 1);
        check("incr4_bad.err_seq", 64'(err_seq), 64'd1);
        drain("incr4");

        clear_flags();
        check_flags("after_clear");
        seqq.delete();
        seqq.push_back(mk(NONSEQ, 32'h48, 0, 3'd2, 3'd2, 32'h0, $urandom, 2'd0, 2'd0));
        seqq.push_back(mk(SEQ,    32'h4C, 0, 3'd2, 3'd2, 32'h0, $urandom, 2'd1, 2'd0));
        seqq.push_back(mk(SEQ,    32'h40, 0, 3'd2, 3'd2, 32'h0, $urandom, 2'd0, 2'd0));
        seqq.push_back(mk(SEQ,    32'h44, 0, 3'd2, 3'd2, 32'h0, $urandom, 2'd0, 2'd0));
        run_seq("wrap4", 1);
        seqq.delete();
        seqq.push_back(mk(SEQ, 32'h80, 1, 3'd3, 3'd1, $urandom, 32'h0, 2'd0, 2'd0));
        run_seq("orphan_seq_big_size", 1);
        drain("wrap");

        do_reset();
        txn_ready = 0;
        seqq.delete();
        for (int i = 0; i < 5; i++)
            seqq.push_back(mk(NONSEQ, 32'h1000 + 32'(16 * i), 1, 3'd2, 3'd1,
                              32'hA000_0000 + 32'(i), 32'h0, 2'd0, 2'd0));
        run_seq("overflow", 0);
        check("overflow.err_ovf_set", 64'(err_ovf), 64'd1);
        drain("overflow");

        do_reset();
        txn_ready = 1;
        seqq.delete();
        seqq.push_back(mk(NONSEQ, 32'h300, 0, 3'd2, 3'd0, 32'h0, 32'hBAD0BAD0, 2'd0, 2'd1));
        run_seq("err_two_cycle", 1);
        seqq.delete();
        seqq.push_back(mk(NONSEQ, 32'h304, 1, 3'd2, 3'd0, 32'h5555AAAA, 32'h0, 2'd1, 2'd2));
        run_seq("err_single_cycle", 1);
        clear_flags();
        check("err_clear.err_resp", 64'(err_resp), 64'd0);
        drain("errors");

        do_reset();
        txn_ready = 0;
        seqq.delete();
        seqq.push_back(mk(NONSEQ, 32'h400, 1, 3'd2, 3'd0, 32'h11, 32'h0, 2'd0, 2'd0));
        seqq.push_back(mk(NONSEQ, 32'h404, 1, 3'd2, 3'd0, 32'h22, 32'h0, 2'd0, 2'd0));
        run_seq("pre_reset", 1);
        put_addr(mk(NONSEQ, 32'h500, 1, 3'd2, 3'd0, 32'h0, 32'h0, 2'd0, 2'd0));
        HREADY = 1;
        cyc();
        put_idle();
        HREADY = 0;
        cyc();
        HRESET = 1;
        cyc();
        check("midreset.txn_valid", 64'(txn_valid), 64'd0);
        check("midreset.txn_count", 64'(txn_count), 64'd0);
        model_reset();
        HRESET = 0;
        HREADY = 1;
        txn_ready = 1;
        for (int i = 0; i < 4; i++) cyc();
        check("midreset.no_partial", 64'(txn_valid), 64'd0);
        check_flags("midreset");

        do_reset();
        rand_ready = 1;
        for (int n = 0; n < 40; n++) begin
            seqq.delete();
            len = $urandom_range(1, 5);
            sz = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            bt = 3'($urandom_range(0, 7));
            a = $urandom & 32'hFFFF_FF00;
            for (int i = 0; i < len; i++) begin
                rr = $urandom_range(0, 19);
                rm = (rr < 15) ? 2'd0 : (rr < 18) ? 2'd1 : 2'd2;
                seqq.push_back(mk((i == 0) ? (($urandom_range(0, 9) == 0) ? SEQ : NONSEQ)
                                           : (($urandom_range(0, 9) == 0) ? NONSEQ : SEQ),
                                  a, 1'($urandom_range(0, 1)), sz, bt, $urandom, $urandom,
                                  2'($urandom_range(0, 2)), rm));
                a = a + (32'd1 << sz);
                if ($urandom_range(0, 9) == 0) a = a + 32'd4;
            end
            run_seq("random", 1);
        end
        drain("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got time %0t, expected completion earlier", $time);
        $fatal(1, "timeout");
    end
endmodule
